// File: rtl/hc280_share_ctrl.sv
// hc280_share_ctrl: shares one 9-bit parity checker between N_REQ requesters.
// The arbiter is round-robin. The word is held on the checker for SETTLE cycles,
// then the checker is sampled and the requester gets a one-cycle ack.
//
// state  | meaning
// IDLE   | waiting for a request; the winner's word is latched on exit
// SETTLE | word held on checker; counter runs to SETTLE-1, then sample
// DONE   | ack pulse to the granted requester; pointer advances on exit
module hc280_share_ctrl #(
  parameter int N_REQ      = 4,
  parameter int SETTLE     = 3,
  parameter int ODD_PARITY = 1,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [9*N_REQ-1:0] req_data_i,
  output logic [8:0]         chk_data_o,
  input  logic               chk_pe_i,
  input  logic               chk_po_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic               result_ok_o,
  output logic               busy_o,
  input  logic               err_clr_i,
  output logic [ERR_W-1:0]   err_count_o,
  output logic               fault_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [8:0]         chk_data_q, chk_data_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ok_q, ok_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fault_q, fault_d;

  logic [8:0]         words [N_REQ];
  logic               gnt_found;
  logic [IW-1:0]      gnt_idx;
  logic [8:0]         gnt_word;
  logic [IW:0]        cand_sum;
  logic [IW-1:0]      cand;
  logic               sample_en;
  logic               pass;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data_i[9*g +: 9];
  end

  assign sample_en = (state_q == S_SETTLE) && (cnt_q == CW'(SETTLE - 1));
  // A checker showing pe == po fails under either polarity rule.
  assign pass = (ODD_PARITY != 0) ? (chk_po_i & ~chk_pe_i) : (chk_pe_i & ~chk_po_i);

  // Round-robin search upward from the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_word  = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N_REQ)) cand_sum = cand_sum - (IW+1)'(N_REQ);
      cand = cand_sum[IW-1:0];
      if (!gnt_found && req_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
        gnt_word  = words[cand];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_found) state_d = S_SETTLE;
      S_SETTLE: if (sample_en) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch word at grant, count settle, sample and score.
  always_comb begin
    chk_data_d = chk_data_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ok_d       = ok_q;
    err_d      = err_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          chk_data_d = gnt_word;
          grant_d    = gnt_idx;
          cnt_d      = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (sample_en) ok_d = pass;
      end
      S_DONE: ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
      default: ;
    endcase
    if (sample_en && !pass && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
    if (sample_en && (chk_pe_i == chk_po_i)) fault_d = 1'b1;
    // Clear wins over a failure landing on the same edge.
    if (err_clr_i) begin
      err_d   = '0;
      fault_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_data_q <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      chk_data_q <= chk_data_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      fault_q    <= fault_d;
    end
  end

  // Outputs: ack is decoded from DONE so it lasts exactly one cycle.
  always_comb begin
    ack_o = '0;
    if (state_q == S_DONE) ack_o[grant_q] = 1'b1;
    busy_o      = (state_q != S_IDLE);
    chk_data_o  = chk_data_q;
    result_ok_o = ok_q;
    err_count_o = err_q;
    fault_o     = fault_q;
  end

endmodule

// File: tb/tb_hc280_share_ctrl.sv
// Bench for hc280_share_ctrl: transaction-timeline model plus directed scenarios.
module tb_hc280_share_ctrl;
  localparam int N   = 4;
  localparam int S   = 3;
  localparam int ODD = 1;
  localparam int EW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] req_data = '0;
  logic           err_clr = 1'b0;
  logic           force_bad = 1'b0;
  logic           chk_pe, chk_po;
  logic [8:0]     chk_data;
  logic [N-1:0]   ack;
  logic           result_ok, busy, fault;
  logic [EW-1:0]  err_count;

  // Ideal parity checker, with an override that shorts pe and po high.
  assign chk_pe = force_bad ? 1'b1 : ~^chk_data;
  assign chk_po = force_bad ? 1'b1 :  ^chk_data;

  hc280_share_ctrl #(.N_REQ(N), .SETTLE(S), .ODD_PARITY(ODD), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_data_i(req_data),
    .chk_data_o(chk_data), .chk_pe_i(chk_pe), .chk_po_i(chk_po),
    .ack_o(ack), .result_ok_o(result_ok), .busy_o(busy),
    .err_clr_i(err_clr), .err_count_o(err_count), .fault_o(fault));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: a grant at edge g completes at edge g+S and frees the
  // arbiter for edge g+S+2; the pointer moves past the winner at edge g+S+1.
  int         m_grant_edge = -1, m_ack_edge = -1, m_next_free = 0;
  int         m_grant = 0, m_ptr = 0;
  logic [8:0] m_word = '0;
  logic [8:0] exp_chk_data = '0;
  logic [N-1:0] exp_ack = '0;
  logic       exp_ok = 1'b0, exp_busy = 1'b0, exp_fault = 1'b0;
  int         exp_err = 0;

  always @(posedge clk) begin
    bit done_now, good;
    int g;
    cyc++;
    if (!rst_n) begin
      m_grant_edge = -1; m_ack_edge = -1; m_next_free = cyc + 1;
      m_ptr = 0; exp_chk_data = '0; exp_ack = '0; exp_ok = 1'b0;
      exp_busy = 1'b0; exp_fault = 1'b0; exp_err = 0;
    end else begin
      done_now = (cyc == m_ack_edge);
      good = 1'b0;
      if (done_now) begin
        if (force_bad) good = 1'b0;
        else if (ODD != 0) good = ($countones(m_word) % 2) == 1;
        else good = ($countones(m_word) % 2) == 0;
        exp_ok = good;
      end
      if (err_clr) begin
        exp_err = 0; exp_fault = 1'b0;
      end else if (done_now) begin
        if (!good && exp_err < (1 << EW) - 1) exp_err++;
        if (force_bad) exp_fault = 1'b1;
      end
      if (m_ack_edge >= 0 && cyc == m_ack_edge + 1) m_ptr = (m_grant + 1) % N;
      exp_ack = done_now ? N'(1 << m_grant) : '0;
      if (cyc >= m_next_free && req != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        m_grant = g;
        m_word = req_data[g*9 +: 9];
        exp_chk_data = m_word;
        m_grant_edge = cyc;
        m_ack_edge = cyc + S;
        m_next_free = cyc + S + 2;
      end
      exp_busy = (m_grant_edge >= 0) && (cyc >= m_grant_edge) && (cyc <= m_ack_edge);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("m_ack",       32'(ack),       32'(exp_ack));
      check("m_busy",      32'(busy),      32'(exp_busy));
      check("m_chk_data",  32'(chk_data),  32'(exp_chk_data));
      check("m_result_ok", 32'(result_ok), 32'(exp_ok));
      check("m_err_count", 32'(err_count), 32'(exp_err));
      check("m_fault",     32'(fault),     32'(exp_fault));
    end
  end

  task automatic wait_ack(output int idx, output int edge_n);
    idx = -1; edge_n = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int k = 0; k < N; k++) if (ack[k]) idx = k;
        edge_n = cyc;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL ack_timeout at edge %0d: got no ack expected one within 40 cycles", cyc);
  endtask

  initial begin
    int idx, e, g;
    int order [5];
    int at [5];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset / idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_chk_data", 32'(chk_data), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // Single passing word from requester 0
    req_data[8:0] = 9'h001;
    req = 4'b0001;
    g = cyc + 1;
    @(negedge clk);
    check("sp_chk_data", 32'(chk_data), 32'h001);
    wait_ack(idx, e);
    req = '0;
    check("sp_idx", 32'(idx), 32'd0);
    check("sp_latency", 32'(e - g), 32'd3);
    check("sp_ok", 32'(result_ok), 32'd1);
    check("sp_err", 32'(err_count), 32'd0);
    @(negedge clk);
    check("sp_ack_len", 32'(ack), 32'h0);

    // Round robin with all four requesting
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_data = {9'h100, 9'h01F, 9'h007, 9'h001};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack(order[i], at[i]);
    req = '0;
    for (int i = 0; i < 5; i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++) check("rr_spacing", 32'(at[i] - at[i-1]), 32'd5);

    // Failing word from requester 2, 260 times: counter saturates at 255
    req_data[26:18] = 9'h003;
    req = 4'b0100;
    for (int i = 0; i < 260; i++) begin
      wait_ack(idx, e);
      if (idx < 0) break;
      if (i == 259) req = '0;
      check("sat_ok", 32'(result_ok), 32'd0);
      if (i == 0 || i == 259) check("sat_idx", 32'(idx), 32'd2);
    end
    req = '0;
    @(negedge clk);
    check("sat_err", 32'(err_count), 32'd255);

    // Clear, then checker fault
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", 32'(err_count), 32'd0);
    force_bad = 1'b1;
    req_data[8:0] = 9'h001;
    req = 4'b0001;
    wait_ack(idx, e);
    req = '0;
    check("flt_ok", 32'(result_ok), 32'd0);
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_err", 32'(err_count), 32'd1);
    repeat (3) @(negedge clk);
    check("flt_sticky", 32'(fault), 32'd1);

    // Clear on the same edge as a failing completion
    req = 4'b0001;
    g = cyc + 1;
    while (cyc < g + S - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    req = '0;
    check("clr_race_ack", 32'(ack), 32'h1);
    check("clr_race_err", 32'(err_count), 32'd0);
    check("clr_race_fault", 32'(fault), 32'd0);
    force_bad = 1'b0;
    repeat (2) @(negedge clk);

    // Reset at the second SETTLE edge, then requester 0 must win first
    req_data[8:0] = 9'h0FE;
    req_data[17:9] = 9'h00B;
    req = 4'b0010;
    g = cyc + 1;
    while (cyc < g + 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ack", 32'(ack), 32'h0);
    req = 4'b0011;
    g = cyc + 1;
    wait_ack(idx, e);
    req = '0;
    check("mid_first_idx", 32'(idx), 32'd0);
    check("mid_latency", 32'(e - g), 32'd3);
    check("mid_ok", 32'(result_ok), 32'd1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
